// File: rtl/uart_tx_drain.sv
// Serial UART transmitter that drains a TX FIFO one word per frame.
// Frame: start bit, data LSB-first, optional parity bit, one or two stop bits.
module uart_tx_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic [DIV_WIDTH-1:0]  baud_div_i,
  input  logic                  parity_en_i,
  input  logic                  parity_odd_i,
  input  logic                  two_stop_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  fifo_pop_o,
  output logic                  tx_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  // state  | meaning
  // IDLE   | line high, pop the FIFO head when enabled and non-empty
  // START  | start bit (line low)
  // DATA   | data bits, LSB first
  // PARITY | parity bit, only when parity was latched on
  // STOP   | one or two stop bits (line high)
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] shift_nxt;
  logic [DIV_WIDTH-1:0]  div_q;
  logic [DIV_WIDTH-1:0]  baud_cnt;
  logic [BW-1:0]         bit_cnt;
  logic                  par_en_q;
  logic                  two_stop_q;
  logic                  parity_q;
  logic                  stop_left;
  logic                  tx_q;
  logic                  bit_end;

  assign bit_end    = (baud_cnt == '0);
  assign shift_nxt  = shift_q >> 1;
  // Gated by rst_ni so no pop can be seen while reset holds the FSM in IDLE.
  assign fifo_pop_o = rst_ni & (state == IDLE) & enable_i & ~fifo_empty_i;
  assign tx_o       = tx_q;
  assign busy_o     = (state != IDLE);
  assign done_o     = (state == STOP) & bit_end & ~stop_left;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      shift_q    <= '0;
      div_q      <= '0;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      par_en_q   <= 1'b0;
      two_stop_q <= 1'b0;
      parity_q   <= 1'b0;
      stop_left  <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (fifo_pop_o) begin
            shift_q    <= fifo_data_i;
            div_q      <= baud_div_i;
            baud_cnt   <= baud_div_i;
            par_en_q   <= parity_en_i;
            two_stop_q <= two_stop_i;
            parity_q   <= (^fifo_data_i) ^ parity_odd_i;
            bit_cnt    <= '0;
            tx_q       <= 1'b0;
            state      <= START;
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= div_q;
            tx_q     <= shift_q[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= div_q;
            shift_q  <= shift_nxt;
            if (bit_cnt == LAST_BIT) begin
              if (par_en_q) begin
                tx_q  <= parity_q;
                state <= PARITY;
              end else begin
                tx_q      <= 1'b1;
                stop_left <= two_stop_q;
                state     <= STOP;
              end
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
              tx_q    <= shift_nxt[0];
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        PARITY: begin
          if (bit_end) begin
            baud_cnt  <= div_q;
            tx_q      <= 1'b1;
            stop_left <= two_stop_q;
            state     <= STOP;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (stop_left) begin
              stop_left <= 1'b0;
              baud_cnt  <= div_q;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_drain.sv
// Scoreboard bench for uart_tx_drain: stimulus queues expected frames, a
// negedge monitor matches every pop and every line cycle against them.
module tb_uart_tx_drain;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] baud_div;
  logic        parity_en, parity_odd, two_stop;
  logic        fifo_empty;
  logic [7:0]  fifo_data;
  logic        fifo_pop, tx, busy, done;

  always #5 clk = ~clk;

  uart_tx_drain #(.DATA_WIDTH(8), .DIV_WIDTH(16)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .enable_i     (enable),
    .baud_div_i   (baud_div),
    .parity_en_i  (parity_en),
    .parity_odd_i (parity_odd),
    .two_stop_i   (two_stop),
    .fifo_empty_i (fifo_empty),
    .fifo_data_i  (fifo_data),
    .fifo_pop_o   (fifo_pop),
    .tx_o         (tx),
    .busy_o       (busy),
    .done_o       (done)
  );

  // bits[i] is the i-th bit on the line (bit 0 = start bit)
  typedef struct {
    int          div;
    int          nbits;
    logic [11:0] bits;
    int          gap;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] fifo_q[$];
  int         errors = 0;
  int         checks = 0;

  task automatic chk(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- monitor ----------------
  exp_t cur;
  bit   in_frame = 1'b0;
  bit   prev_pop = 1'b0;
  int   pos = 0;
  int   last_pos = 0;
  int   bidx = 0;
  int   cyc_cnt = 0;
  int   last_pop_cyc = 0;

  always @(negedge clk) begin
    cyc_cnt++;
    if (!rst_n) begin
      if (in_frame) begin
        chk(tx == 1'b1, "reset_abort_tx", int'(tx), 1);
        chk(busy == 1'b0, "reset_abort_busy", int'(busy), 0);
        chk(fifo_pop == 1'b0, "reset_abort_pop", int'(fifo_pop), 0);
        in_frame = 1'b0;
      end
      prev_pop = 1'b0;
    end else begin
      if (in_frame) begin
        bidx = pos / (cur.div + 1);
        chk(tx == cur.bits[bidx], "tx_bit", int'(tx), int'(cur.bits[bidx]));
        chk(busy == 1'b1, "busy_in_frame", int'(busy), 1);
        chk(done == (pos == last_pos), "done_pulse", int'(done), int'(pos == last_pos));
        if (fifo_pop) chk(1'b0, "pop_mid_frame", 1, 0);
        if (pos == last_pos) in_frame = 1'b0;
        else pos++;
      end else if (fifo_pop) begin
        chk(tx == 1'b1 && busy == 1'b0 && done == 1'b0, "pop_cycle_idle",
            int'({tx, busy, done}), 4);
        chk(!prev_pop, "pop_consecutive", int'(prev_pop), 0);
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_pop", 1, 0);
        end else begin
          cur = exp_q.pop_front();
          if (cur.gap != 0)
            chk(cyc_cnt - last_pop_cyc == cur.gap, "pop_gap", cyc_cnt - last_pop_cyc, cur.gap);
          in_frame = 1'b1;
          pos      = 0;
          last_pos = cur.nbits * (cur.div + 1) - 1;
        end
        last_pop_cyc = cyc_cnt;
      end else begin
        chk(tx == 1'b1 && busy == 1'b0 && done == 1'b0, "idle_line",
            int'({tx, busy, done}), 4);
      end
      prev_pop = fifo_pop;
    end
  end

  // ---------------- FIFO model and stimulus ----------------
  task automatic fifo_update();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? 8'h00 : fifo_q[0];
  endtask

  task automatic push_word(input logic [7:0] w);
    fifo_q.push_back(w);
    fifo_update();
  endtask

  task automatic tick(output bit popped);
    @(posedge clk);
    popped = fifo_pop;
    #1;
    if (popped && fifo_q.size() > 0) void'(fifo_q.pop_front());
    fifo_update();
  endtask

  task automatic ticks(input int n);
    bit p;
    for (int i = 0; i < n; i++) tick(p);
  endtask

  task automatic expect_frame(input int div, input int nbits, input logic [11:0] bits,
                              input int gap);
    exp_t e;
    e.div = div; e.nbits = nbits; e.bits = bits; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic wait_pop(input string name);
    bit p = 1'b0;
    int n = 0;
    while (!p && n < 200) begin
      tick(p);
      n++;
    end
    if (!p) chk(1'b0, {name, "_pop_timeout"}, 0, 1);
  endtask

  task automatic wait_idle(input string name);
    bit p;
    int n = 0;
    while ((exp_q.size() != 0 || in_frame || busy) && n < 2000) begin
      tick(p);
      n++;
    end
    if (n >= 2000) chk(1'b0, {name, "_idle_timeout"}, 0, 1);
    ticks(3);
  endtask

  task automatic set_cfg(input int div, input bit pen, input bit podd, input bit ts);
    baud_div   = 16'(div);
    parity_en  = pen;
    parity_odd = podd;
    two_stop   = ts;
  endtask

  initial begin
    rst_n = 1'b0;
    enable = 1'b1;
    set_cfg(3, 1'b0, 1'b0, 1'b0);
    fifo_update();
    ticks(3);
    chk(tx == 1'b1, "reset_tx", int'(tx), 1);
    chk(busy == 1'b0, "reset_busy", int'(busy), 0);
    chk(done == 1'b0, "reset_done", int'(done), 0);
    chk(fifo_pop == 1'b0, "reset_pop", int'(fifo_pop), 0);
    rst_n = 1'b1;

    // empty FIFO with enable high: idle line, no pop
    ticks(10);

    // basic frame 0xA5, div=3, no parity, 1 stop
    expect_frame(3, 10, 12'h34A, 0);
    push_word(8'hA5);
    wait_idle("basic");

    // parity on 0xA5, div=0: even then odd
    set_cfg(0, 1'b1, 1'b0, 1'b0);
    expect_frame(0, 11, 12'h54A, 0);
    push_word(8'hA5);
    wait_idle("par_even");
    set_cfg(0, 1'b1, 1'b1, 1'b0);
    expect_frame(0, 11, 12'h74A, 0);
    push_word(8'hA5);
    wait_idle("par_odd");

    // back-to-back, even parity, two stop, div=1
    set_cfg(1, 1'b1, 1'b0, 1'b1);
    expect_frame(1, 12, 12'hE02, 0);
    expect_frame(1, 12, 12'hDFE, 25);
    push_word(8'h01);
    push_word(8'hFF);
    wait_idle("b2b");

    // config change during DATA only affects the next frame
    set_cfg(3, 1'b0, 1'b0, 1'b0);
    expect_frame(3, 10, 12'h278, 0);
    expect_frame(0, 11, 12'h478, 41);
    push_word(8'h3C);
    wait_pop("cfg");
    ticks(8);
    set_cfg(0, 1'b1, 1'b0, 1'b0);
    push_word(8'h3C);
    wait_idle("cfg");

    // enable dropped during START: frame completes, 0x66 stays queued
    set_cfg(1, 1'b0, 1'b0, 1'b0);
    expect_frame(1, 10, 12'h2AA, 0);
    push_word(8'h55);
    push_word(8'h66);
    wait_pop("gate");
    enable = 1'b0;
    wait_idle("gate");
    ticks(30);
    chk(fifo_q.size() == 1, "gate_fifo_left", fifo_q.size(), 1);

    // reset during DATA bit 3, then a fresh frame pops after release
    set_cfg(3, 1'b0, 1'b0, 1'b0);
    expect_frame(3, 10, 12'h2CC, 0);
    enable = 1'b1;
    wait_pop("rst");
    push_word(8'h81);
    ticks(17);
    rst_n = 1'b0;
    ticks(2);
    chk(in_frame == 1'b0, "reset_seen", int'(in_frame), 0);
    expect_frame(3, 10, 12'h302, 0);
    rst_n = 1'b1;
    wait_idle("after_rst");
    chk(fifo_q.size() == 0, "fifo_drained", fifo_q.size(), 0);
    chk(exp_q.size() == 0, "scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_drain.md
Name: uart_tx_drain

Overview:
Serial UART transmitter that sits directly downstream of the TX buffer FIFO. Pops one word whenever the FIFO is non-empty and the line is idle, then shifts it out as an asynchronous serial frame: start, data LSB-first, optional parity, 1 or 2 stop bits. Runtime line configuration comes from the peripheral's control registers.

Parameters:
DATA_WIDTH, 8, number of data bits per frame; also the FIFO word width.
DIV_WIDTH, 16, width of the baud divisor input.

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous reset, active low
enable_i  input  1  allow new frames to start
baud_div_i  input  DIV_WIDTH  clock cycles per bit minus 1
parity_en_i  input  1  insert parity bit
parity_odd_i  input  1  1 = odd parity, 0 = even parity
two_stop_i  input  1  1 = two stop bits, 0 = one stop bit
fifo_empty_i  input  1  FIFO empty flag
fifo_data_i  input  DATA_WIDTH  FIFO head word (valid whenever not empty)
fifo_pop_o  output  1  pop FIFO head this cycle
tx_o  output  1  serial line, idle high
busy_o  output  1  frame in progress
done_o  output  1  one-cycle pulse on the last cycle of a frame

Behaviour:
- Reset values (async, immediate): state IDLE; tx_o=1, busy_o=0, done_o=0, fifo_pop_o=0; all counters and shift register 0.
- States: IDLE, START, DATA, PARITY, STOP.
- fifo_pop_o is combinational: (state==IDLE) & enable_i & ~fifo_empty_i. It is never high outside IDLE and never high for more than one consecutive cycle.
- Pop cycle captures the following:
  - fifo_data_i into the shift register.
  - baud_div_i, parity_en_i, parity_odd_i and two_stop_i into frame-config registers.
  - parity = ^data ^ parity_odd_i.
  - Next state is START.
- Config inputs that change mid-frame have no effect until the next pop.
- Bit timing: every bit lasts exactly div+1 cycles, where div is the latched divisor. The baud counter loads div on entering a bit and decrements to 0. At 0 the FSM advances to the next bit. div=0 gives 1 cycle per bit.
- Line levels per state:
  - START: tx_o=0.
  - DATA: tx_o=shift[0]; shift right after each bit; a bit counter counts DATA_WIDTH bits.
  - PARITY: tx_o=parity bit; entered only if parity_en latched, else DATA goes directly to STOP.
  - STOP: tx_o=1 for one bit period, or two if two_stop latched.
- done_o is high on the final cycle of the last stop bit; the next state is IDLE.
- busy_o = (state != IDLE).
- tx_o is driven from a register and is glitch-free.
- Back-to-back frames: IDLE lasts at least 1 cycle (tx_o=1), and the pop occurs in that cycle.
  - Frame period = (1+DATA_WIDTH+P+S)*(div+1)+1 cycles, where P is the parity bit count (0/1) and S is the stop bit count (1/2).
- enable_i deasserted mid-frame: the current frame completes normally and no further pop occurs.
- FIFO empty in IDLE: remain IDLE with tx_o=1.
- Reset asserted mid-frame: the frame is aborted immediately and tx_o returns high. The popped word is lost, with no re-pop.

Test Plan:
- Basic frame: DATA_WIDTH=8, div=3, no parity, 1 stop, FIFO holds 0xA5, enable=1.
  - fifo_pop_o high for exactly 1 cycle.
  - tx_o starting the next cycle, 4 cycles per bit: 0,1,0,1,0,0,1,0,1,1.
  - done_o pulses on cycle 40 after the pop; busy_o high for 40 cycles.
- Parity on 0xA5 (four ones), div=0:
  - Even: parity bit 0.
  - Odd: parity bit 1.
  - Frame is 11 bit-times with 1 stop.
- Back-to-back, two_stop=1, div=1, FIFO holds 0x01 then 0xFF:
  - Pops are 25 cycles apart: 12 bits*2 + 1 idle.
  - Second frame data bits are all 1.
  - Exactly 2 pops total, then tx_o stays 1 with busy_o=0.
- Config change mid-frame: change baud_div_i 3->0 and parity_en_i 0->1 during DATA.
  - Current frame keeps 4 cycles/bit with no parity.
  - Next frame uses 1 cycle/bit with parity.
- Gating: FIFO empty with enable=1 gives no pop and tx_o=1. enable dropped during START: frame completes, no further pop despite a non-empty FIFO.
- Reset mid-frame: assert rst_ni low during DATA bit 3.
  - tx_o=1, busy_o=0 and fifo_pop_o=0 in the same cycle.
  - After release with a non-empty FIFO, a fresh frame starts with a new pop.
